uart_tx_arb: RTL

//  Round-robin arbiter/sequencer that shares one byte-wide UART transmitter between NREQ requesters.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_tx_arb_if.sv | 33 +++
 rtl/rr_pick.sv | 34 +++
 rtl/uart_tx_arb.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SEND    = 3'd1,
      WAIT_LO = 3'd2,
      WAIT_HI = 3'd3,
      HOLD    = 3'd4
   } arb_state_e;

   localparam int WAIT_LO_RETRY = 4;
   localparam int RETRY_W       = $clog2(WAIT_LO_RETRY);
   localparam int HOLD_TO_DEF   = 50000;
   localparam int HOLD_CNT_W    = 16;
   localparam int UART_DW       = 8;

   // Successor of a requester index, wrapping the last one back to zero.
   function automatic int rr_next(input int idx, input int nreq);
      return (idx >= nreq - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/uart_tx_arb_if.sv
// Requester-side and transmitter-side signal bundle of the UART transmit arbiter.
interface uart_tx_arb_if
   import uart_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) ();

   logic [NREQ-1:0]         req_valid;
   logic [UART_DW*NREQ-1:0] req_data;
   logic [NREQ-1:0]         req_last;
   logic [NREQ-1:0]         req_ready;
   logic                    tx_write;
   logic [UART_DW-1:0]      tx_data;
   logic                    txrdy;
   logic                    grant_vld;
   logic [IDW-1:0]          grant_id;
   logic                    pkt_done;
   logic                    hold_to_err;

   // Environment side: requesters plus the transmitter's ready flag.
   modport master (
      output req_valid, req_data, req_last, txrdy,
      input  req_ready, tx_write, tx_data, grant_vld, grant_id, pkt_done, hold_to_err
   );

   // Arbiter side.
   modport slave (
      input  req_valid, req_data, req_last, txrdy,
      output req_ready, tx_write, tx_data, grant_vld, grant_id, pkt_done, hold_to_err
   );

endinterface

// File: rtl/rr_pick.sv
// Round-robin picker: rotate requests so ptr_i is bit 0, take the lowest set bit,
// then rotate the found offset back into an absolute index.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] req_i,
   input  logic [IDW-1:0]  ptr_i,
   output logic            any_o,
   output logic [IDW-1:0]  idx_o
);

   logic [2*NREQ-1:0] dbl;
   logic [NREQ-1:0]   rot;
   int                off;
   int                sum;

   always_comb begin
      dbl   = {req_i, req_i} >> ptr_i;
      rot   = dbl[NREQ-1:0];
      any_o = 1'b0;
      off   = 0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (rot[i]) begin
            any_o = 1'b1;
            off   = i;
         end
      end
      sum = int'(ptr_i) + off;
      if (sum >= NREQ) sum = sum - NREQ;
      idx_o = IDW'(sum);
   end

endmodule

// File: rtl/uart_tx_arb.sv
// Shares one byte-wide UART transmitter between NREQ requesters, granting whole
// packets round-robin and pacing each byte on the transmitter's txrdy flag.
module uart_tx_arb
   import uart_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int IDW     = 2,
   parameter int HOLD_TO = HOLD_TO_DEF
) (
   input  logic           clk,
   input  logic           rst_n,
   uart_tx_arb_if.slave   bus
);

   arb_state_e              state_q, state_d;
   logic [IDW-1:0]          rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]          grant_id_q, grant_id_d;
   logic                    grant_vld_q, grant_vld_d;
   logic [UART_DW-1:0]      tx_data_q, tx_data_d;
   logic                    tx_write_q, tx_write_d;
   logic                    last_q, last_d;
   logic                    pkt_done_q, pkt_done_d;
   logic                    hold_to_err_q, hold_to_err_d;
   logic [RETRY_W-1:0]      retry_q, retry_d;
   logic [HOLD_CNT_W-1:0]   hold_cnt_q, hold_cnt_d;

   logic                    pick_any;
   logic [IDW-1:0]          pick_idx;
   logic                    ld_en;
   logic [IDW-1:0]          ld_idx;
   logic [NREQ-1:0]         ready;

   rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
      .req_i (bus.req_valid),
      .ptr_i (rr_ptr_q),
      .any_o (pick_any),
      .idx_o (pick_idx)
   );

   always_comb begin
      state_d       = state_q;
      rr_ptr_d      = rr_ptr_q;
      grant_id_d    = grant_id_q;
      grant_vld_d   = grant_vld_q;
      tx_data_d     = tx_data_q;
      tx_write_d    = 1'b0;
      last_d        = last_q;
      pkt_done_d    = 1'b0;
      hold_to_err_d = 1'b0;
      retry_d       = retry_q;
      hold_cnt_d    = hold_cnt_q;
      ld_en         = 1'b0;
      ld_idx        = grant_id_q;
      ready         = '0;

      case (state_q)
         IDLE: begin
            if (bus.txrdy && pick_any) begin
               ld_en  = 1'b1;
               ld_idx = pick_idx;
            end
         end
         SEND: begin
            retry_d = '0;
            state_d = WAIT_LO;
         end
         WAIT_LO: begin
            // A load the transmitter never acknowledged is simply re-issued.
            if (!bus.txrdy) begin
               state_d = WAIT_HI;
            end else if (retry_q == RETRY_W'(WAIT_LO_RETRY - 1)) begin
               tx_write_d = 1'b1;
               state_d    = SEND;
            end else begin
               retry_d = retry_q + 1'b1;
            end
         end
         WAIT_HI: begin
            if (bus.txrdy) begin
               if (last_q) begin
                  pkt_done_d  = 1'b1;
                  grant_vld_d = 1'b0;
                  rr_ptr_d    = IDW'(rr_next(int'(grant_id_q), NREQ));
                  state_d     = IDLE;
               end else begin
                  hold_cnt_d = '0;
                  state_d    = HOLD;
               end
            end
         end
         HOLD: begin
            // Accept beats timeout when both fall in the same cycle.
            if (bus.txrdy && bus.req_valid[grant_id_q]) begin
               ld_en  = 1'b1;
               ld_idx = grant_id_q;
            end else if (hold_cnt_q == HOLD_CNT_W'(HOLD_TO - 1)) begin
               hold_to_err_d = 1'b1;
               grant_vld_d   = 1'b0;
               rr_ptr_d      = IDW'(rr_next(int'(grant_id_q), NREQ));
               state_d       = IDLE;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      for (int i = 0; i < NREQ; i++) begin
         if (ld_en && (IDW'(i) == ld_idx)) begin
            ready[i]  = 1'b1;
            tx_data_d = bus.req_data[i*UART_DW +: UART_DW];
            last_d    = bus.req_last[i];
         end
      end
      if (ld_en) begin
         grant_id_d  = ld_idx;
         grant_vld_d = 1'b1;
         tx_write_d  = 1'b1;
         state_d     = SEND;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         rr_ptr_q      <= '0;
         grant_id_q    <= '0;
         grant_vld_q   <= 1'b0;
         tx_data_q     <= '0;
         tx_write_q    <= 1'b0;
         last_q        <= 1'b0;
         pkt_done_q    <= 1'b0;
         hold_to_err_q <= 1'b0;
         retry_q       <= '0;
         hold_cnt_q    <= '0;
      end else begin
         state_q       <= state_d;
         rr_ptr_q      <= rr_ptr_d;
         grant_id_q    <= grant_id_d;
         grant_vld_q   <= grant_vld_d;
         tx_data_q     <= tx_data_d;
         tx_write_q    <= tx_write_d;
         last_q        <= last_d;
         pkt_done_q    <= pkt_done_d;
         hold_to_err_q <= hold_to_err_d;
         retry_q       <= retry_d;
         hold_cnt_q    <= hold_cnt_d;
      end
   end

   // The strobe is decoded from state, so it is forced low while reset is held.
   assign bus.req_ready   = rst_n ? ready : '0;
   assign bus.tx_write    = tx_write_q;
   assign bus.tx_data     = tx_data_q;
   assign bus.grant_vld   = grant_vld_q;
   assign bus.grant_id    = grant_id_q;
   assign bus.pkt_done    = pkt_done_q;
   assign bus.hold_to_err = hold_to_err_q;

endmodule
